apb_cmd_master: RTL

APB initiator that turns single-word command requests into APB3 transfers on the I2C controller's register port. It sits between the test/firmware-model side and the I2C block's APB slave: commands enter on a valid/ready channel, SETUP/ACCESS phases are driven per protocol, the slave's `prdata`/`pslverr` are sampled on `pready`, and results come back on a response channel. A programmable wait-state timeout guarantees forward progress against a hung slave.

---
 rtl/apb_cmd_master.sv | 134 +++++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// APB3 initiator: accepts one command at a time on a valid/ready channel, runs a
// SETUP/ACCESS transfer with an optional wait-state timeout, and returns a held response.
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  apb_clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [1:0]            dbg_state
);

  // Both channels use strict valid/ready: a transfer happens on the rising edge where
  // valid and ready are both high; a valid source holds its payload until then.

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             cmd_fire;
  logic             done_ok;
  logic             done_to;

  assign dbg_state = state;

  always_comb begin
    state_next = state;
    cmd_fire   = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    cmd_ready  = (state == S_IDLE) && !rsp_valid;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_fire   = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_SETUP: state_next = S_ACCESS;
      S_ACCESS: begin
        // A slave completing on the last permitted cycle wins over the timeout.
        if (pready) begin
          done_ok    = 1'b1;
          state_next = S_IDLE;
        end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
          done_to    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge apb_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      state   <= state_next;
      psel    <= (state_next != S_IDLE);
      penable <= (state_next == S_ACCESS);
    end
  end

  always_ff @(posedge apb_clk) begin
    if (reset) begin
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // Bus address/data only change on a new command, so they hold through IDLE.
      if (cmd_fire) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end

      if (state_next == S_SETUP) begin
        wait_cnt <= '0;
      end else if ((state == S_ACCESS) && !pready && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (done_ok) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (done_to) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
